ma_access_unit: RTL and testbench
=================================

MA_ACCESS_UNIT -- requirements
Module: ma_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256, SHALL set the number of REQ cycles without mem_ack before abort.
REQ-002 clk  input  1  single clock; all registers SHALL update on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 input_MA_PC  input  32  PC from the EX/MA latch.
REQ-005 input_MA_ALU_Result  input  32  effective address or ALU result.
REQ-006 input_MA_op2  input  32  store data.
REQ-007 input_MA_IR  input  32  instruction word.
REQ-008 input_MA_controlBus  input  22  control bus; bit CB_IS_ST means store, bit CB_IS_LD means load.
REQ-009 in_valid  input  1  the latch holds a live instruction.
REQ-010 stall_o  output  1  freeze the upstream latches.
REQ-011 mem_req  output  1  data-memory request.
REQ-012 mem_we  output  1  1 = store, 0 = load.
REQ-013 mem_addr  output  32  memory address.
REQ-014 mem_wdata  output  32  store data.
REQ-015 mem_rdata  input  32  load data, valid when mem_ack = 1.
REQ-016 mem_ack  input  1  one-cycle completion pulse.
REQ-017 output_MA_PC, output_MA_ALU_Result, output_MA_ld_result, output_MA_IR  output  32 each  results to MA/RW.
REQ-018 output_MA_controlBus  output  22  control bus forwarded to MA/RW.
REQ-019 out_valid  output  1  one-cycle pulse; all output_MA_* fields are valid in that cycle.
REQ-020 mem_err  output  1  sticky timeout flag.

Function
REQ-021 The state machine SHALL have two states, IDLE and REQ.
REQ-022 IDLE, in_valid = 1, no mem op:
- next edge: output_MA_* <= inputs, output_MA_ld_result <= 0, out_valid <= 1;
- latency 1 cycle;
- stall_o = 0.
REQ-023 IDLE, in_valid = 1, mem op (CB_IS_LD or CB_IS_ST):
- stall_o = 1 combinationally;
- next edge: capture all input fields, then mem_addr <= ALU_Result, mem_wdata <= op2, mem_we <= CB_IS_ST, mem_req <= 1;
- state -> REQ; cycle counter <= 0.
REQ-024 If both CB_IS_LD and CB_IS_ST are set, the access SHALL be treated as a store.
REQ-025 In REQ, mem_req, mem_we, mem_addr and mem_wdata SHALL be held stable until mem_ack or timeout.
REQ-026 In REQ without mem_ack, stall_o SHALL be 1 and the counter SHALL increment by one per cycle.
REQ-027 In REQ with mem_ack = 1:
- stall_o SHALL drop to 0 in the same cycle;
- next edge: mem_req <= 0, out_valid <= 1, output_MA_* <= captured fields, state -> IDLE;
- output_MA_ld_result <= mem_rdata for a load, 0 for a store.
REQ-028 When the counter reaches TIMEOUT_CYCLES-1 without mem_ack:
- the access SHALL abort exactly as in REQ-027 with output_MA_ld_result = 0;
- mem_err <= 1, held until reset.
REQ-029 mem_ack that coincides with the timeout cycle SHALL win: complete normally, mem_err unchanged.
REQ-030 mem_ack received in IDLE SHALL be ignored.
REQ-031 out_valid SHALL be 0 in every cycle not covered by REQ-022, REQ-027 or REQ-028.
REQ-032 Inputs SHALL be sampled only in IDLE; input changes during REQ SHALL have no effect.
REQ-033 Back-to-back accesses SHALL be permitted: a new instruction may be accepted in IDLE in the cycle after completion.

Reset
REQ-034 rst = 1 SHALL immediately set:
- state = IDLE;
- mem_req, mem_we, out_valid, mem_err = 0;
- every 32-bit and 22-bit output = 0;
- counter = 0.
REQ-035 Reset during REQ SHALL drop mem_req asynchronously and discard the access without producing out_valid.

Structure
REQ-036 A shared package SHALL hold CB_IS_LD = 15, CB_IS_ST = 14, the state enum and the default for TIMEOUT_CYCLES.
REQ-037 The timeout counter SHALL be a sub-module named ma_timeout_counter (inputs clear and enable, output expired).

Verification
REQ-038 ALU op, in_valid = 1, ALU_Result = 0x0000_0055 -> one cycle later out_valid = 1, output_MA_ALU_Result = 0x55, stall_o never high.
REQ-039 Load, ALU_Result = 0x100, mem_ack after 3 cycles with mem_rdata = 0xDEAD_BEEF:
- mem_addr = 0x100, mem_we = 0;
- output_MA_ld_result = 0xDEADBEEF;
- stall_o high 4 cycles.
REQ-040 Store, ALU_Result = 0x200, op2 = 0x1234, ack after 1 cycle -> mem_we = 1, mem_wdata = 0x1234, output_MA_ld_result = 0.
REQ-041 Load with mem_ack never asserted, TIMEOUT_CYCLES = 8 -> abort after 8 REQ cycles, mem_err = 1, out_valid pulse, ld_result = 0.
REQ-042 rst asserted 2 cycles into a load -> mem_req = 0 asynchronously, no out_valid, next instruction accepted normally.
REQ-043 mem_ack pulse in IDLE -> no output change.

Source files
------------

// File: rtl/ma_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// ma_access_unit_pkg
// Shared definitions for the memory-access stage: control-bus bit positions,
// the access FSM state type, the default abort timeout and a small helper
// that classifies a control-bus word as a memory operation.
// ---------------------------------------------------------------------------
package ma_access_unit_pkg;

  localparam int CB_W                   = 22;
  localparam int CB_IS_LD               = 15;
  localparam int CB_IS_ST               = 14;
  localparam int TIMEOUT_CYCLES_DEFAULT = 256;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } ma_state_t;

  // A word is a memory access when it is a load, a store, or both.
  function automatic logic is_mem_op(input logic [CB_W-1:0] cb);
    return cb[CB_IS_LD] | cb[CB_IS_ST];
  endfunction

endpackage

// File: rtl/ma_timeout_counter.sv
// ---------------------------------------------------------------------------
// ma_timeout_counter
// Counts cycles spent waiting for a memory acknowledge.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart the count from zero (takes priority over enable)
//   enable   : advance the count by one this cycle
//   expired  : the count currently sits at TIMEOUT_CYCLES-1
// The count saturates at its terminal value so it can never wrap while the
// owner is still deciding what to do with the expiry.
// ---------------------------------------------------------------------------
module ma_timeout_counter
  import ma_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // Wait-cycle counter: clear on a new access, count while enabled, saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= {CW{1'b0}};
    end else if (clear) begin
      r_count <= {CW{1'b0}};
    end else if (enable && (r_count != LAST)) begin
      r_count <= r_count + CW'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign expired = (r_count == LAST);

endmodule

// File: rtl/ma_access_unit.sv
// ---------------------------------------------------------------------------
// ma_access_unit
// Memory-access pipeline stage. Non-memory instructions pass to MA/RW in one
// cycle. Loads/stores are captured, presented on the data-memory port and
// held until mem_ack or until TIMEOUT_CYCLES request cycles elapse, at which
// point the access is aborted and the sticky mem_err flag is raised.
//   clk, rst                 : clock, asynchronous active-high reset
//   input_MA_* / in_valid    : EX/MA latch contents
//   stall_o                  : combinational freeze of the upstream latches
//   mem_req/we/addr/wdata    : registered data-memory request
//   mem_rdata/mem_ack        : memory response (ack is a one-cycle pulse)
//   output_MA_* / out_valid  : registered results, valid for one cycle
//   mem_err                  : sticky timeout flag
// ---------------------------------------------------------------------------
module ma_access_unit
  import ma_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      input_MA_PC,
  input  logic [31:0]      input_MA_ALU_Result,
  input  logic [31:0]      input_MA_op2,
  input  logic [31:0]      input_MA_IR,
  input  logic [CB_W-1:0]  input_MA_controlBus,
  input  logic             in_valid,
  output logic             stall_o,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic [31:0]      output_MA_PC,
  output logic [31:0]      output_MA_ALU_Result,
  output logic [31:0]      output_MA_ld_result,
  output logic [31:0]      output_MA_IR,
  output logic [CB_W-1:0]  output_MA_controlBus,
  output logic             out_valid,
  output logic             mem_err
);

  ma_state_t r_state;
  ma_state_t w_state_nxt;

  logic w_is_mem;
  logic w_is_st;
  logic w_accept_alu;
  logic w_accept_mem;
  logic w_done;
  logic w_stall;
  logic w_expired;
  logic w_cnt_enable;

  // Fields captured at acceptance and replayed to MA/RW on completion.
  // The ALU result lives in r_mem_addr, which already holds it.
  logic [31:0]     r_cap_pc;
  logic [31:0]     r_cap_ir;
  logic [CB_W-1:0] r_cap_cb;

  logic            r_mem_req;
  logic            r_mem_we;
  logic [31:0]     r_mem_addr;
  logic [31:0]     r_mem_wdata;

  logic [31:0]     r_out_pc;
  logic [31:0]     r_out_alu;
  logic [31:0]     r_out_ld;
  logic [31:0]     r_out_ir;
  logic [CB_W-1:0] r_out_cb;
  logic            r_out_valid;
  logic            r_mem_err;

  assign w_is_mem     = is_mem_op(input_MA_controlBus);
  // A word flagged as both load and store is handled as a store.
  assign w_is_st      = input_MA_controlBus[CB_IS_ST];
  // The counter only advances on request cycles that end without an ack.
  assign w_cnt_enable = (r_state == ST_REQ) && !mem_ack;

  ma_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_accept_mem),
    .enable  (w_cnt_enable),
    .expired (w_expired)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, stall and transaction-event decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_stall      = 1'b0;
    w_accept_alu = 1'b0;
    w_accept_mem = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid && w_is_mem) begin
          w_accept_mem = 1'b1;
          w_stall      = 1'b1;
          w_state_nxt  = ST_REQ;
        end else if (in_valid) begin
          w_accept_alu = 1'b1;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Ack and abort both release the pipeline this cycle; an ack that
        // lands on the expiry cycle still completes normally.
        if (mem_ack || w_expired) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_stall     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Capture, memory request and MA/RW result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_pc    <= 32'd0;
      r_cap_ir    <= 32'd0;
      r_cap_cb    <= {CB_W{1'b0}};
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_out_pc    <= 32'd0;
      r_out_alu   <= 32'd0;
      r_out_ld    <= 32'd0;
      r_out_ir    <= 32'd0;
      r_out_cb    <= {CB_W{1'b0}};
      r_out_valid <= 1'b0;
      r_mem_err   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept_alu) begin
        r_out_pc    <= input_MA_PC;
        r_out_alu   <= input_MA_ALU_Result;
        r_out_ld    <= 32'd0;
        r_out_ir    <= input_MA_IR;
        r_out_cb    <= input_MA_controlBus;
        r_out_valid <= 1'b1;
      end else if (w_accept_mem) begin
        r_cap_pc    <= input_MA_PC;
        r_cap_ir    <= input_MA_IR;
        r_cap_cb    <= input_MA_controlBus;
        r_mem_addr  <= input_MA_ALU_Result;
        r_mem_wdata <= input_MA_op2;
        r_mem_we    <= w_is_st;
        r_mem_req   <= 1'b1;
      end else if (w_done) begin
        r_mem_req   <= 1'b0;
        r_out_pc    <= r_cap_pc;
        r_out_alu   <= r_mem_addr;
        r_out_ir    <= r_cap_ir;
        r_out_cb    <= r_cap_cb;
        r_out_valid <= 1'b1;
        // Only an acknowledged load returns data; stores and aborts give 0.
        if (mem_ack && !r_mem_we) begin
          r_out_ld <= mem_rdata;
        end else begin
          r_out_ld <= 32'd0;
        end
        if (!mem_ack) begin
          r_mem_err <= 1'b1;
        end else begin
          r_mem_err <= r_mem_err;
        end
      end else begin
        r_mem_req <= r_mem_req;
      end
    end
  end

  assign stall_o              = w_stall;
  assign mem_req              = r_mem_req;
  assign mem_we               = r_mem_we;
  assign mem_addr             = r_mem_addr;
  assign mem_wdata            = r_mem_wdata;
  assign output_MA_PC         = r_out_pc;
  assign output_MA_ALU_Result = r_out_alu;
  assign output_MA_ld_result  = r_out_ld;
  assign output_MA_IR         = r_out_ir;
  assign output_MA_controlBus = r_out_cb;
  assign out_valid            = r_out_valid;
  assign mem_err              = r_mem_err;

endmodule

// File: tb/tb_ma_access_unit.sv
// ---------------------------------------------------------------------------
// tb_ma_access_unit
// Transaction-level bench: each instruction is described by its kind and the
// number of request cycles before the memory acknowledges; the expected
// stall pattern, result fields and error flag follow from those alone.
// Inputs change and outputs are sampled around the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ma_access_unit;
  import ma_access_unit_pkg::*;

  localparam int T = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     input_MA_PC;
  logic [31:0]     input_MA_ALU_Result;
  logic [31:0]     input_MA_op2;
  logic [31:0]     input_MA_IR;
  logic [CB_W-1:0] input_MA_controlBus;
  logic            in_valid;
  logic            stall_o;
  logic            mem_req;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata;
  logic            mem_ack;
  logic [31:0]     output_MA_PC;
  logic [31:0]     output_MA_ALU_Result;
  logic [31:0]     output_MA_ld_result;
  logic [31:0]     output_MA_IR;
  logic [CB_W-1:0] output_MA_controlBus;
  logic            out_valid;
  logic            mem_err;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference view of the MA/RW outputs and the sticky error flag.
  logic [31:0]     m_pc, m_alu, m_ld, m_ir;
  logic [CB_W-1:0] m_cb;
  logic            m_err;

  always #5 clk = ~clk;

  ma_access_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .input_MA_PC          (input_MA_PC),
    .input_MA_ALU_Result  (input_MA_ALU_Result),
    .input_MA_op2         (input_MA_op2),
    .input_MA_IR          (input_MA_IR),
    .input_MA_controlBus  (input_MA_controlBus),
    .in_valid             (in_valid),
    .stall_o              (stall_o),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_rdata            (mem_rdata),
    .mem_ack              (mem_ack),
    .output_MA_PC         (output_MA_PC),
    .output_MA_ALU_Result (output_MA_ALU_Result),
    .output_MA_ld_result  (output_MA_ld_result),
    .output_MA_IR         (output_MA_IR),
    .output_MA_controlBus (output_MA_controlBus),
    .out_valid            (out_valid),
    .mem_err              (mem_err)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic exp_ov);
    check_val({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, exp_ov});
    check_val({tag, ".pc"},  output_MA_PC,         m_pc);
    check_val({tag, ".alu"}, output_MA_ALU_Result, m_alu);
    check_val({tag, ".ld"},  output_MA_ld_result,  m_ld);
    check_val({tag, ".ir"},  output_MA_IR,         m_ir);
    check_val({tag, ".cb"},  {10'd0, output_MA_controlBus}, {10'd0, m_cb});
    check_val({tag, ".err"}, {31'd0, mem_err},     {31'd0, m_err});
  endtask

  task automatic scramble_inputs();
    input_MA_PC         = $urandom;
    input_MA_ALU_Result = $urandom;
    input_MA_op2        = $urandom;
    input_MA_IR         = $urandom;
    input_MA_controlBus = CB_W'($urandom);
    in_valid            = 1'($urandom_range(0, 1));
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_alu = 32'd0; m_ld = 32'd0; m_ir = 32'd0;
    m_cb = {CB_W{1'b0}}; m_err = 1'b0;
  endtask

  // One cycle with no live instruction; a stray ack must be ignored.
  task automatic idle_cycle();
    scramble_inputs();
    in_valid  = 1'b0;
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    check_val("idle.stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    check_outs("idle", 1'b0);
    check_val("idle.req", {31'd0, mem_req}, 32'd0);
  endtask

  // kind: 0 ALU, 1 load, 2 store, 3 load+store (acts as store).
  // delay: request cycles without ack before the ack; >= T means the ack
  // never arrives in time and the access aborts.
  task automatic run_txn(input int kind, input int delay, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd);
    logic [CB_W-1:0] cb;
    logic [31:0]     pc, ir;
    logic            is_mem, is_st, term, acked;
    int              stalls, want_stalls;
    cb = CB_W'($urandom);
    cb[CB_IS_LD] = (kind == 1) || (kind == 3);
    cb[CB_IS_ST] = (kind == 2) || (kind == 3);
    pc = $urandom;
    ir = $urandom;
    is_mem = (kind != 0);
    is_st  = (kind >= 2);
    want_stalls = is_mem ? 1 + ((delay < T - 1) ? delay : T - 1) : 0;
    stalls = 0;

    input_MA_PC = pc; input_MA_ALU_Result = addr; input_MA_op2 = wd;
    input_MA_IR = ir; input_MA_controlBus = cb; in_valid = 1'b1;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    if (stall_o) stalls++;
    check_val("accept.stall", {31'd0, stall_o}, {31'd0, is_mem});
    @(negedge clk);

    if (!is_mem) begin
      m_pc = pc; m_alu = addr; m_ld = 32'd0; m_ir = ir; m_cb = cb;
      check_outs("alu", 1'b1);
      check_val("alu.req", {31'd0, mem_req}, 32'd0);
      check_val("alu.stalls", 32'(stalls), 32'(want_stalls));
    end else begin
      check_outs("issue", 1'b0);
      check_val("issue.req",   {31'd0, mem_req}, 32'd1);
      check_val("issue.we",    {31'd0, mem_we},  {31'd0, is_st});
      check_val("issue.addr",  mem_addr,  addr);
      check_val("issue.wdata", mem_wdata, wd);
      term = 1'b0;
      for (int k = 0; k < T && !term; k++) begin
        scramble_inputs();
        acked = (k == delay);
        mem_ack   = acked;
        mem_rdata = acked ? rd : $urandom;
        term = acked || (k == T - 1);
        #1;
        if (stall_o) stalls++;
        check_val("req.stall", {31'd0, stall_o}, {31'd0, !term});
        @(negedge clk);
        if (term) begin
          m_pc = pc; m_alu = addr; m_ir = ir; m_cb = cb;
          m_ld = (acked && !is_st) ? rd : 32'd0;
          if (!acked) m_err = 1'b1;
          check_outs("done", 1'b1);
          check_val("done.req", {31'd0, mem_req}, 32'd0);
          check_val("done.stalls", 32'(stalls), 32'(want_stalls));
        end else begin
          check_outs("wait", 1'b0);
          check_val("wait.req",   {31'd0, mem_req}, 32'd1);
          check_val("wait.we",    {31'd0, mem_we},  {31'd0, is_st});
          check_val("wait.addr",  mem_addr,  addr);
          check_val("wait.wdata", mem_wdata, wd);
        end
      end
    end
  endtask

  // Reset two request cycles into a load: request drops at once, no result.
  task automatic reset_mid_load();
    input_MA_PC = $urandom; input_MA_ALU_Result = 32'h0000_0300;
    input_MA_op2 = $urandom; input_MA_IR = $urandom;
    input_MA_controlBus = {CB_W{1'b0}};
    input_MA_controlBus[CB_IS_LD] = 1'b1;
    in_valid = 1'b1; mem_ack = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rstmid.req_before", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    check_val("rstmid.req_async", {31'd0, mem_req}, 32'd0);
    check_outs("rstmid", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    check_outs("rstmid.hold", 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    input_MA_PC = 32'd0; input_MA_ALU_Result = 32'd0; input_MA_op2 = 32'd0;
    input_MA_IR = 32'd0; input_MA_controlBus = {CB_W{1'b0}};
    in_valid = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
    model_reset();
    @(negedge clk);
    check_outs("reset", 1'b0);
    check_val("reset.req",   {31'd0, mem_req}, 32'd0);
    check_val("reset.we",    {31'd0, mem_we},  32'd0);
    check_val("reset.addr",  mem_addr,  32'd0);
    check_val("reset.wdata", mem_wdata, 32'd0);
    check_val("reset.stall", {31'd0, stall_o}, 32'd0);
    rst = 1'b0;

    run_txn(0, 0,     32'h0000_0055, $urandom,      $urandom);
    run_txn(1, 3,     32'h0000_0100, $urandom,      32'hDEAD_BEEF);
    run_txn(2, 1,     32'h0000_0200, 32'h0000_1234, $urandom);
    run_txn(3, 0,     $urandom,      $urandom,      $urandom);
    run_txn(1, T - 1, $urandom,      $urandom,      $urandom);
    idle_cycle();
    idle_cycle();
    run_txn(1, 100,   32'h0000_0400, $urandom,      $urandom);
    idle_cycle();
    run_txn(0, 0,     $urandom,      $urandom,      $urandom);
    reset_mid_load();
    idle_cycle();
    run_txn(1, 2,     $urandom,      $urandom,      $urandom);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, T + 2)),
              $urandom, $urandom, $urandom);
    end
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
